// File: rtl/lfsr_period_monitor.sv
// Follows an LFSR state stream from a captured seed until it closes, and reports
// the period, maximal-length pass, and lock-up / duplicate / abort errors.
module lfsr_period_monitor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sel,
   input  logic [WIDTH-1:0] state,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [WIDTH:0]   period,
   output logic [1:0]       err,
   output logic             fsm_state
);

   localparam int             DEPTH      = 1 << WIDTH;
   localparam logic [WIDTH:0] MAX_PERIOD = (WIDTH + 1)'(DEPTH - 1);
   localparam logic [WIDTH:0] CNT_ONE    = (WIDTH + 1)'(1);

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_LOCK  = 2'b01;
   localparam logic [1:0] ERR_DUP   = 2'b10;
   localparam logic [1:0] ERR_ABORT = 2'b11;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } fsm_t;

   fsm_t             fsm_q, fsm_d;
   logic             sel_q;
   logic [WIDTH-1:0] seed_q, seed_d;
   logic [WIDTH:0]   cnt_q, cnt_d;
   logic [DEPTH-1:0] seen_q, seen_d;
   logic             busy_d, done_d, pass_d;
   logic [WIDTH:0]   period_d;
   logic [1:0]       err_d;
   logic             start;
   logic             end_run;

   // A start needs sel_q=0, so it can only be seen in IDLE; in RUN that edge aborts.
   assign start     = sel & ~sel_q;
   assign fsm_state = (fsm_q == RUN);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm_q  <= IDLE;
         sel_q  <= 1'b0;
         seed_q <= '0;
         cnt_q  <= '0;
         seen_q <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         pass   <= 1'b0;
         period <= '0;
         err    <= ERR_NONE;
      end else begin
         fsm_q  <= fsm_d;
         sel_q  <= sel;
         seed_q <= seed_d;
         cnt_q  <= cnt_d;
         seen_q <= seen_d;
         busy   <= busy_d;
         done   <= done_d;
         pass   <= pass_d;
         period <= period_d;
         err    <= err_d;
      end
   end

   always_comb begin
      fsm_d    = fsm_q;
      seed_d   = seed_q;
      cnt_d    = cnt_q;
      seen_d   = seen_q;
      busy_d   = busy;
      done_d   = 1'b0;
      pass_d   = pass;
      period_d = period;
      err_d    = err;
      end_run  = 1'b0;

      case (fsm_q)
         IDLE: begin
            if (start) begin
               seed_d        = state;
               seen_d        = '0;
               seen_d[state] = 1'b1;
               cnt_d         = CNT_ONE;
               pass_d        = 1'b0;
               period_d      = '0;
               err_d         = ERR_NONE;
               if (state == '0) begin
                  err_d   = ERR_LOCK;
                  end_run = 1'b1;
               end else begin
                  busy_d = 1'b1;
                  fsm_d  = RUN;
               end
            end
         end
         RUN: begin
            if (!sel) begin
               err_d   = ERR_ABORT;
               end_run = 1'b1;
            end else if (state == seed_q) begin
               period_d = cnt_q;
               pass_d   = (cnt_q == MAX_PERIOD);
               end_run  = 1'b1;
            end else if (state == '0) begin
               err_d   = ERR_LOCK;
               end_run = 1'b1;
            end else if (seen_q[state]) begin
               err_d   = ERR_DUP;
               end_run = 1'b1;
            end else begin
               seen_d[state] = 1'b1;
               cnt_d         = cnt_q + CNT_ONE;
            end
         end
         default: fsm_d = IDLE;
      endcase

      if (end_run) begin
         busy_d = 1'b0;
         done_d = 1'b1;
         fsm_d  = IDLE;
      end
   end

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// Bench for lfsr_period_monitor: a reference x^4+x^3+1 LFSR or a directed state
// stream drives the monitor; each run's expected report is queued for the done monitor.
module tb_lfsr_period_monitor;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         sel = 1'b0;
   logic [W-1:0] state;
   logic         busy, done, pass, fsm_state;
   logic [W:0]   period;
   logic [1:0]   err;

   logic         use_lfsr = 1'b0;
   logic [W-1:0] lfsr = '0;
   logic [W-1:0] lfsr_seed = '0;
   logic [W-1:0] drv_state = '0;

   int n_checks = 0;
   int n_pass = 0;
   int cyc = 0;

   // {done edge index[15:0], period[4:0], pass, err[1:0]}
   logic [23:0] exp_q[$];
   logic [23:0] mon_e;

   lfsr_period_monitor #(.WIDTH(W)) dut (
      .clk(clk),
      .rst(rst_n),
      .sel(sel),
      .state(state),
      .busy(busy),
      .done(done),
      .pass(pass),
      .period(period),
      .err(err),
      .fsm_state(fsm_state)
   );

   assign state = use_lfsr ? lfsr : drv_state;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!sel) lfsr <= lfsr_seed;
      else      lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
   end

   task automatic chk(input string name, input int act, input int exp_v);
      n_checks++;
      if (act == exp_v) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
   endtask

   // lat = edges after the start edge at which the run ends
   task automatic push_exp(input int lat, input logic [4:0] p, input logic ps, input logic [1:0] e);
      exp_q.push_back({16'(cyc + 1 + lat), p, ps, e});
   endtask

   always @(negedge clk) begin
      if (rst_n && done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("done_edge", cyc, int'(mon_e[23:8]));
            chk("period", int'(period), int'(mon_e[7:3]));
            chk("pass", int'(pass), int'(mon_e[2]));
            chk("err", int'(err), int'(mon_e[1:0]));
            chk("busy_at_done", int'(busy), 0);
         end
      end
   end

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_pass"}, int'(pass), 0);
      chk({tag, "_period"}, int'(period), 0);
      chk({tag, "_err"}, int'(err), 0);
      chk({tag, "_fsm"}, int'(fsm_state), 0);
   endtask

   task automatic run_lfsr(input logic [3:0] seed);
      use_lfsr  = 1'b1;
      lfsr_seed = seed;
      sel       = 1'b0;
      @(negedge clk);
      sel = 1'b1;
      push_exp(15, 5'd15, 1'b1, 2'b00);
      repeat (17) @(negedge clk);
      chk("pass_held", int'(pass), 1);
      chk("period_held", int'(period), 15);
      sel = 1'b0;
      @(negedge clk);
   endtask

   task automatic drive_stream(input logic [3:0] vals[8], input int n, input int lat,
                               input logic [4:0] p, input logic ps, input logic [1:0] e);
      use_lfsr  = 1'b0;
      sel       = 1'b0;
      drv_state = vals[0];
      @(negedge clk);
      sel = 1'b1;
      push_exp(lat, p, ps, e);
      for (int i = 0; i < n; i++) begin
         drv_state = vals[i];
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
      sel = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Maximal-length runs from the real LFSR
      run_lfsr(4'b1111);
      run_lfsr(4'b1001);
      run_lfsr(4'b0001);
      run_lfsr(4'b1101);

      // Seed 0 locks up on the start edge itself
      drive_stream('{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0}, 1, 0, 5'd0, 1'b0, 2'b01);
      // 0101 repeats at E3
      drive_stream('{4'b0011, 4'b0101, 4'b1000, 4'b0101, 4'h0, 4'h0, 4'h0, 4'h0}, 4, 3, 5'd0, 1'b0, 2'b10);
      // Short closed cycle of four states
      drive_stream('{4'b0110, 4'b1010, 4'b0001, 4'b1110, 4'b0110, 4'h0, 4'h0, 4'h0}, 5, 4, 5'd4, 1'b0, 2'b00);

      // Abort at E7, then restart one cycle later
      use_lfsr  = 1'b1;
      lfsr_seed = 4'b1001;
      sel       = 1'b0;
      @(negedge clk);
      sel = 1'b1;
      push_exp(7, 5'd0, 1'b0, 2'b11);
      repeat (7) @(negedge clk);
      sel = 1'b0;
      @(negedge clk);
      sel = 1'b1;
      push_exp(15, 5'd15, 1'b1, 2'b00);
      repeat (17) @(negedge clk);
      sel = 1'b0;
      @(negedge clk);

      // Asynchronous reset mid-run discards the run
      lfsr_seed = 4'b1001;
      @(negedge clk);
      sel = 1'b1;
      repeat (6) @(negedge clk);
      chk("busy_mid_run", int'(busy), 1);
      chk("fsm_mid_run", int'(fsm_state), 1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_all_zero("async_rst");
      @(negedge clk);
      sel = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      run_lfsr(4'b1001);

      for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      repeat (5) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
